// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC sequencer:
// sequencer states, default widths and a constant-safe clog2 helper.
package fir_pkg;

   localparam int M_DEF     = 16;
   localparam int N_DEF     = 32;
   localparam int TAPS_DEF  = 8;
   localparam int ACC_W_DEF = 40;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE
   } state_e;

   // Smallest r with 2**r >= value; usable in parameter/port declarations.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient, multiplier and result signals of the FIR MAC sequencer.
// slave is the sequencer side; master is the surrounding filter/source side.
interface fir_mac_sequencer_if
   import fir_pkg::*;
#(
   parameter int M     = M_DEF,
   parameter int N     = N_DEF,
   parameter int TAPS  = TAPS_DEF,
   parameter int ACC_W = ACC_W_DEF
);

   localparam int AW = clog2(TAPS);

   logic                    in_valid;
   logic signed [M-1:0]     in_data;
   logic                    in_ready;

   logic                    coef_we;
   logic        [AW-1:0]    coef_addr;
   logic signed [M-1:0]     coef_data;

   logic signed [M-1:0]     mul_a;
   logic signed [M-1:0]     mul_b;
   logic signed [N-1:0]     mul_res;

   logic                    out_valid;
   logic signed [ACC_W-1:0] out_data;
   logic                    out_ready;

   modport slave (
      input  in_valid, in_data, coef_we, coef_addr, coef_data, mul_res, out_ready,
      output in_ready, mul_a, mul_b, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, coef_we, coef_addr, coef_data, mul_res, out_ready,
      input  in_ready, mul_a, mul_b, out_valid, out_data
   );

endinterface

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register: x[0] takes the newest sample on shift,
// and one tap is read out combinationally by index.
module fir_delay_line
   import fir_pkg::*;
#(
   parameter  int M     = M_DEF,
   parameter  int TAPS  = TAPS_DEF,
   localparam int IDX_W = clog2(TAPS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                shift_i,
   input  logic signed [M-1:0] din_i,
   input  logic [IDX_W-1:0]    idx_i,
   output logic signed [M-1:0] dout_o
);

   logic signed [M-1:0] x_q [TAPS];

   // NOTE: the delay line is reset on purpose -- an aborted run must leave no
   // stale samples behind, so this stays flops rather than a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      end else if (shift_i) begin
         x_q[0] <= din_i;
         for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
   end

   assign dout_o = x_q[idx_i];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR control/accumulation stage: feeds one (sample, coefficient) pair per
// cycle to an external multiplier and sums the products into one output.
module fir_mac_sequencer
   import fir_pkg::*;
#(
   parameter int M     = M_DEF,
   parameter int N     = N_DEF,
   parameter int TAPS  = TAPS_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   fir_mac_sequencer_if.slave  bus
);

   localparam int IDX_W = clog2(TAPS);

   state_e                  state_q;
   logic [IDX_W-1:0]        idx_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] out_data_q;
   logic                    out_valid_q;
   logic signed [M-1:0]     h_q [TAPS];
   logic signed [M-1:0]     x_sel;
   logic                    accept;

   assign accept = (state_q == IDLE) && bus.in_valid;

   fir_delay_line #(
      .M    (M),
      .TAPS (TAPS)
   ) u_delay_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .shift_i (accept),
      .din_i   (bus.in_data),
      .idx_i   (idx_q),
      .dout_o  (x_sel)
   );

   assign acc_d = acc_q + {{(ACC_W-N){bus.mul_res[N-1]}}, bus.mul_res};

   // NOTE: every output of this block gets a default before the branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      bus.mul_a = '0;
      bus.mul_b = '0;
      if (state_q == MAC) begin
         bus.mul_a = x_sel;
         bus.mul_b = h_q[idx_q];
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // Coefficients are only writable while no MAC run is using them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) h_q[k] <= '0;
      end else if (state_q == IDLE && bus.coef_we) begin
         h_q[bus.coef_addr] <= bus.coef_data;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= MAC;
               end
            end
            MAC: begin
               acc_q <= acc_d;
               idx_q <= idx_q + 1'b1;
               if (idx_q == IDX_W'(TAPS - 1)) begin
                  out_data_q  <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a behavioural signed multiplier
// closing the mul_a/mul_b -> mul_res loop.
module tb_fir_mac_sequencer;
   import fir_pkg::*;

   localparam int M     = 16;
   localparam int N     = 32;
   localparam int TAPS  = 8;
   localparam int ACC_W = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   fir_mac_sequencer_if #(.M(M), .N(N), .TAPS(TAPS), .ACC_W(ACC_W)) bus ();

   fir_mac_sequencer #(.M(M), .N(N), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic signed [N-1:0] a_ext;
   logic signed [N-1:0] b_ext;
   assign a_ext       = N'(bus.mul_a);
   assign b_ext       = N'(bus.mul_b);
   assign bus.mul_res = a_ext * b_ext;

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic write_coef(input int addr, input int data);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 3'(addr);
      bus.coef_data = 16'(data);
      tick();
      bus.coef_we   = 1'b0;
   endtask

   // Called one cycle after the accept edge; out_valid is due 9 cycles after accept.
   task automatic wait_done(input string tag);
      int lat;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, ".lat"}, lat, 9);
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic run_sample(input int d, input logic signed [63:0] exp, input string tag);
      check({tag, ".rdy"}, bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(d);
      tick();
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      wait_done(tag);
      check({tag, ".out"}, bus.out_data, exp);
      consume();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      bus.out_ready = 1'b0;

      // Reset state
      #2;
      check("rst.in_ready", bus.in_ready, 1);
      check("rst.out_valid", bus.out_valid, 0);
      check("rst.out_data", bus.out_data, 0);
      check("rst.mul_a", bus.mul_a, 0);
      check("rst.mul_b", bus.mul_b, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Impulse response with h = 1..8
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      run_sample(1, 1, "imp0");
      for (int k = 1; k <= TAPS; k++)
         run_sample(0, (k == TAPS) ? 0 : k + 1, $sformatf("imp%0d", k));

      // Extreme operands: (-32768)*(-32768) = 2^30 per tap, 2^33 after eight
      for (int k = 0; k < TAPS; k++) write_coef(k, 32'h8000);
      for (int k = 1; k <= TAPS; k++)
         run_sample(32'h8000, longint'(k) <<< 30, $sformatf("ext%0d", k));

      // Mixed sign from a clean delay line, h = -1
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < TAPS; k++) write_coef(k, -1);
      run_sample(100, -100, "mix0");
      run_sample(-300, 200, "mix1");

      // Backpressure: x = [7,-300,100,0..] -> 193; source holds 999 meanwhile
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(7);
      tick();
      bus.in_valid = 1'b0;
      wait_done("bp0");
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(999);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp.hold%0d.valid", i), bus.out_valid, 1);
         check($sformatf("bp.hold%0d.data", i), bus.out_data, 193);
         check($sformatf("bp.hold%0d.in_ready", i), bus.in_ready, 0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp.idle.in_ready", bus.in_ready, 1);
      check("bp.idle.out_valid", bus.out_valid, 0);
      tick();
      bus.in_valid = 1'b0;
      check("bp.busy.in_ready", bus.in_ready, 0);
      wait_done("bp1");
      check("bp1.out", bus.out_data, -806);
      consume();

      // Coefficient write during MAC/DONE must be ignored
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(2);
      tick();
      bus.in_valid  = 1'b0;
      bus.coef_we   = 1'b1;
      bus.coef_addr = 3'(0);
      bus.coef_data = 16'(5);
      wait_done("cw0");
      check("cw0.out", bus.out_data, -808);
      bus.coef_we = 1'b0;
      consume();
      run_sample(1, -809, "cw1");
      // Write in IDLE together with an accept: new h[0] = 5 used immediately
      bus.coef_we   = 1'b1;
      bus.coef_addr = 3'(0);
      bus.coef_data = 16'(5);
      run_sample(1, -804, "cw2");

      // Reset in the middle of a MAC run
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(5);
      tick();
      bus.in_valid = 1'b0;
      check("mid.idx0.mul_a", bus.mul_a, 5);
      check("mid.idx0.mul_b", bus.mul_b, 5);
      tick();
      tick();
      tick();
      check("mid.idx3.mul_a", bus.mul_a, 2);
      check("mid.idx3.mul_b", bus.mul_b, -1);
      rst_n = 1'b0;
      #1;
      check("mid.rst.out_valid", bus.out_valid, 0);
      check("mid.rst.in_ready", bus.in_ready, 1);
      check("mid.rst.mul_a", bus.mul_a, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid.post.out_valid", bus.out_valid, 0);
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      run_sample(1, 1, "rimp0");
      for (int k = 1; k <= TAPS; k++)
         run_sample(0, (k == TAPS) ? 0 : k + 1, $sformatf("rimp%0d", k));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
